// File: rtl/rps_pkg.sv
// Shared move codes, round result codes and FSM state encoding for the
// stone-paper-scissors match controller and its judge.
package rps_pkg;

  localparam logic [1:0] MOVE_NONE     = 2'b00;
  localparam logic [1:0] MOVE_STONE    = 2'b01;
  localparam logic [1:0] MOVE_PAPER    = 2'b10;
  localparam logic [1:0] MOVE_SCISSORS = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_A    = 2'b01;
  localparam logic [1:0] RES_B    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COLLECT    = 3'd1,
    ST_REVEAL     = 3'd2,
    ST_MATCH_OVER = 3'd3
  } rps_state_e;

  // True when move x defeats move y under the usual cyclic rules.
  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    return ((x == MOVE_STONE)    && (y == MOVE_SCISSORS)) ||
           ((x == MOVE_SCISSORS) && (y == MOVE_PAPER))    ||
           ((x == MOVE_PAPER)    && (y == MOVE_STONE));
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: maps the two locked moves to a 2-bit round result.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] move_a,
  input  logic [1:0] move_b,
  output logic [1:0] result
);

  always_comb begin
    result = RES_DRAW;
    if (move_a != move_b) begin
      result = beats(move_a, move_b) ? RES_A : RES_B;
    end
  end

endmodule

// File: rtl/rps_match_controller.sv
// First-to-WIN_TARGET stone-paper-scissors match sequencer: move collection with
// lockout and forfeit timeout, round reveal window, scoring and winner declaration.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int WIN_TARGET     = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int REVEAL_CYCLES  = 8,
  parameter int SCORE_W        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [1:0]         move_a,
  input  logic               move_a_vld,
  input  logic [1:0]         move_b,
  input  logic               move_b_vld,
  output logic               await_a,
  output logic               await_b,
  output logic [1:0]         round_result,
  output logic               result_vld,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               match_done,
  output logic               match_winner,
  output logic [2:0]         state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(REVEAL_CYCLES + 1);
  localparam logic [TW-1:0]      TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]      RMAX = RW'(REVEAL_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_TARGET);

  rps_state_e         state_q, state_d;
  logic               lock_a_q, lock_a_d, lock_b_q, lock_b_d;
  logic [1:0]         mv_a_q, mv_a_d, mv_b_q, mv_b_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RW-1:0]      reveal_cnt_q, reveal_cnt_d;
  logic [1:0]         result_q, result_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic               winner_q, winner_d;

  logic       acc_a, acc_b, have_a, have_b, judged;
  logic [1:0] cand_a, cand_b, judge_res, res_next;

  // Accept qualification is kept outside the FSM block so the judge sees this
  // cycle's completing move without a combinational loop through the FSM.
  assign acc_a  = ena && (state_q == ST_COLLECT) && !lock_a_q && move_a_vld && (move_a != MOVE_NONE);
  assign acc_b  = ena && (state_q == ST_COLLECT) && !lock_b_q && move_b_vld && (move_b != MOVE_NONE);
  assign have_a = lock_a_q || acc_a;
  assign have_b = lock_b_q || acc_b;
  assign cand_a = acc_a ? move_a : mv_a_q;
  assign cand_b = acc_b ? move_b : mv_b_q;

  rps_judge u_judge (
    .move_a (cand_a),
    .move_b (cand_b),
    .result (judge_res)
  );

  always_comb begin
    state_d      = state_q;
    lock_a_d     = lock_a_q;
    lock_b_d     = lock_b_q;
    mv_a_d       = mv_a_q;
    mv_b_d       = mv_b_q;
    timer_d      = timer_q;
    reveal_cnt_d = reveal_cnt_q;
    result_d     = result_q;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    winner_d     = winner_q;
    judged       = 1'b0;
    res_next     = RES_NONE;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_COLLECT;
            lock_a_d = 1'b0;
            lock_b_d = 1'b0;
            timer_d  = '0;
          end
        end
        ST_COLLECT: begin
          lock_a_d = have_a;
          lock_b_d = have_b;
          mv_a_d   = cand_a;
          mv_b_d   = cand_b;
          // A completing move takes priority over a coincident timeout.
          if (have_a && have_b) begin
            judged   = 1'b1;
            res_next = judge_res;
          end else if (timer_q == TMAX) begin
            judged   = 1'b1;
            res_next = have_a ? RES_A : (have_b ? RES_B : RES_DRAW);
          end else begin
            timer_d = timer_q + TW'(1);
          end
          if (judged) begin
            state_d      = ST_REVEAL;
            reveal_cnt_d = '0;
            result_d     = res_next;
            if (res_next == RES_A && score_a_q != WIN) score_a_d = score_a_q + SCORE_W'(1);
            if (res_next == RES_B && score_b_q != WIN) score_b_d = score_b_q + SCORE_W'(1);
          end
        end
        ST_REVEAL: begin
          if (reveal_cnt_q == RMAX) begin
            reveal_cnt_d = '0;
            if (score_a_q == WIN || score_b_q == WIN) begin
              state_d  = ST_MATCH_OVER;
              winner_d = (score_b_q == WIN);
            end else begin
              state_d  = ST_COLLECT;
              result_d = RES_NONE;
              lock_a_d = 1'b0;
              lock_b_d = 1'b0;
              timer_d  = '0;
            end
          end else begin
            reveal_cnt_d = reveal_cnt_q + RW'(1);
          end
        end
        ST_MATCH_OVER: begin
          if (start) begin
            state_d   = ST_COLLECT;
            score_a_d = '0;
            score_b_d = '0;
            result_d  = RES_NONE;
            lock_a_d  = 1'b0;
            lock_b_d  = 1'b0;
            timer_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lock_a_q     <= 1'b0;
      lock_b_q     <= 1'b0;
      mv_a_q       <= MOVE_NONE;
      mv_b_q       <= MOVE_NONE;
      timer_q      <= '0;
      reveal_cnt_q <= '0;
      result_q     <= RES_NONE;
      score_a_q    <= '0;
      score_b_q    <= '0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_a_q     <= lock_a_d;
      lock_b_q     <= lock_b_d;
      mv_a_q       <= mv_a_d;
      mv_b_q       <= mv_b_d;
      timer_q      <= timer_d;
      reveal_cnt_q <= reveal_cnt_d;
      result_q     <= result_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      winner_q     <= winner_d;
    end
  end

  assign await_a      = (state_q == ST_COLLECT) && !lock_a_q;
  assign await_b      = (state_q == ST_COLLECT) && !lock_b_q;
  assign round_result = result_q;
  assign result_vld   = (state_q == ST_REVEAL);
  assign score_a      = score_a_q;
  assign score_b      = score_b_q;
  assign match_done   = (state_q == ST_MATCH_OVER);
  assign match_winner = winner_q;
  assign state        = state_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller with a short timeout and reveal window.
module tb_rps_match_controller;

  localparam int TO = 16;
  localparam int RV = 4;
  localparam int WT = 3;
  localparam int SW = 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_REVEAL  = 3'd2;
  localparam logic [2:0] S_OVER    = 3'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    move_a = 2'b00;
  logic          move_a_vld = 1'b0;
  logic [1:0]    move_b = 2'b00;
  logic          move_b_vld = 1'b0;
  logic          await_a, await_b, result_vld, match_done, match_winner;
  logic [1:0]    round_result;
  logic [SW-1:0] score_a, score_b;
  logic [2:0]    state;

  rps_match_controller #(
    .WIN_TARGET     (WT),
    .TIMEOUT_CYCLES (TO),
    .REVEAL_CYCLES  (RV),
    .SCORE_W        (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start        (start),
    .move_a       (move_a),
    .move_a_vld   (move_a_vld),
    .move_b       (move_b),
    .move_b_vld   (move_b_vld),
    .await_a      (await_a),
    .await_b      (await_b),
    .round_result (round_result),
    .result_vld   (result_vld),
    .score_a      (score_a),
    .score_b      (score_b),
    .match_done   (match_done),
    .match_winner (match_winner),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entry: {round_result, score_a, score_b} expected at the reveal.
  logic [7:0]    exp_q[$];
  logic [7:0]    exp_v, got_v;
  logic [SW-1:0] exp_sa = '0;
  logic [SW-1:0] exp_sb = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result from the game rules, written independently of the judge.
  function automatic logic [1:0] rule_result(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b11;
    if ((a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) || (a == 2'b10 && b == 2'b01))
      return 2'b01;
    return 2'b10;
  endfunction

  task automatic push_round(input logic [1:0] res);
    if (res == 2'b01) exp_sa = exp_sa + 1'b1;
    if (res == 2'b10) exp_sb = exp_sb + 1'b1;
    exp_q.push_back({res, exp_sa, exp_sb});
  endtask

  task automatic wait_vld(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (!ok && cycles < budget) begin
      if (result_vld) ok = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    int c;
    c = 0;
    while (state !== target && c < budget) begin
      tick();
      c++;
    end
    ok = (state === target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({state, await_a, await_b, result_vld, round_result, score_a, score_b, match_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: state=%0d await=%b%b vld=%b res=%b sa=%0d sb=%0d done=%b, required all 0",
               state, await_a, await_b, result_vld, round_result, score_a, score_b, match_done);
    end
    rst_n = 1'b1;
    ena = 1'b1;
    tick();
    n_cmp++;
    if (state !== S_IDLE) begin
      n_err++;
      $display("FAIL idle_hold: state=%0d, required %0d", state, S_IDLE);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (state !== S_COLLECT || await_a !== 1'b1 || await_b !== 1'b1 ||
        score_a !== '0 || score_b !== '0 || match_done !== 1'b0) begin
      n_err++;
      $display("FAIL start_collect: state=%0d await=%b%b sa=%0d sb=%0d done=%b, required 1 11 0 0 0",
               state, await_a, await_b, score_a, score_b, match_done);
    end
  endtask

  task automatic test_same_cycle_win();
    int cnt;
    bit ok;
    move_a = 2'b01; move_b = 2'b11; move_a_vld = 1'b1; move_b_vld = 1'b1;
    push_round(rule_result(2'b01, 2'b11));
    tick();
    move_a_vld = 1'b0; move_b_vld = 1'b0;
    n_cmp++;
    if (result_vld !== 1'b1 || state !== S_REVEAL) begin
      n_err++;
      $display("FAIL win_latency: vld=%b state=%0d, required 1 %0d", result_vld, state, S_REVEAL);
    end
    got_v = {round_result, score_a, score_b};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL win_round: got %h, required %h", got_v, exp_v);
    end
    cnt = 1;
    tick();
    while (result_vld && cnt < 20) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== RV) begin
      n_err++;
      $display("FAIL reveal_width: vld cycles %0d, required %0d", cnt, RV);
    end
    n_cmp++;
    if (state !== S_COLLECT || round_result !== 2'b00 || await_a !== 1'b1 || await_b !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_collect: state=%0d res=%b await=%b%b, required 1 00 11",
               state, round_result, await_a, await_b);
    end
    ok = 1'b1;
  endtask

  task automatic test_lockout_draw();
    bit ok;
    move_a = 2'b10; move_a_vld = 1'b1;
    tick();
    move_a_vld = 1'b0;
    n_cmp++;
    if (await_a !== 1'b0 || await_b !== 1'b1) begin
      n_err++;
      $display("FAIL lock_a: await=%b%b, required 01", await_a, await_b);
    end
    tick();
    move_a = 2'b01; move_a_vld = 1'b1;
    tick();
    move_a_vld = 1'b0;
    tick();
    tick();
    move_b = 2'b10; move_b_vld = 1'b1;
    push_round(rule_result(2'b10, 2'b10));
    tick();
    move_b_vld = 1'b0;
    n_cmp++;
    if (result_vld !== 1'b1) begin
      n_err++;
      $display("FAIL draw_latency: vld=%b, required 1", result_vld);
    end
    got_v = {round_result, score_a, score_b};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL draw_round: got %h, required %h", got_v, exp_v);
    end
    wait_state(S_COLLECT, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL draw_exit: state=%0d, required %0d", state, S_COLLECT);
    end
  endtask

  task automatic test_forfeit_match();
    bit ok;
    int cyc;
    while (exp_sa < WT) begin
      move_a = 2'($urandom_range(1, 3)); move_a_vld = 1'b1;
      tick();
      move_a_vld = 1'b0;
      push_round(2'b01);
      wait_vld(TO + 10, cyc, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL forfeit_timeout: no result_vld after %0d cycles, required within %0d", cyc, TO);
        void'(exp_q.pop_front());
      end else begin
        got_v = {round_result, score_a, score_b};
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          n_err++;
          $display("FAIL forfeit_round: got %h, required %h", got_v, exp_v);
        end
      end
      if (exp_sa < WT) wait_state(S_COLLECT, 20, ok);
    end
    wait_state(S_OVER, 20, ok);
    n_cmp++;
    if (!ok || match_done !== 1'b1 || match_winner !== 1'b0 || score_a !== SW'(WT) ||
        score_b !== '0 || round_result !== 2'b01) begin
      n_err++;
      $display("FAIL match_over: state=%0d done=%b win=%b sa=%0d sb=%0d res=%b, required 3 1 0 %0d 0 01",
               state, match_done, match_winner, score_a, score_b, round_result, WT);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_sa = '0;
    exp_sb = '0;
    n_cmp++;
    if (state !== S_COLLECT || score_a !== '0 || score_b !== '0 || match_done !== 1'b0) begin
      n_err++;
      $display("FAIL restart: state=%0d sa=%0d sb=%0d done=%b, required 1 0 0 0",
               state, score_a, score_b, match_done);
    end
  endtask

  task automatic test_invalid_freeze_void();
    bit ok;
    int cyc;
    move_a = 2'b00; move_a_vld = 1'b1;
    tick();
    move_a_vld = 1'b0;
    n_cmp++;
    if (await_a !== 1'b1 || state !== S_COLLECT) begin
      n_err++;
      $display("FAIL invalid_code: await_a=%b state=%0d, required 1 1", await_a, state);
    end
    ena = 1'b0;
    move_b = 2'b01; move_b_vld = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    move_b_vld = 1'b0;
    n_cmp++;
    if (state !== S_COLLECT || await_b !== 1'b1 || result_vld !== 1'b0) begin
      n_err++;
      $display("FAIL freeze: state=%0d await_b=%b vld=%b, required 1 1 0", state, await_b, result_vld);
    end
    ena = 1'b1;
    push_round(2'b11);
    wait_vld(TO + 10, cyc, ok);
    n_cmp++;
    if (!ok || cyc !== TO - 1) begin
      n_err++;
      $display("FAIL void_timing: vld after %0d enabled cycles (seen=%b), required %0d", cyc, ok, TO - 1);
    end
    got_v = {round_result, score_a, score_b};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL void_round: got %h, required %h", got_v, exp_v);
    end
  endtask

  task automatic test_reset_in_reveal();
    bit ok;
    wait_state(S_COLLECT, 20, ok);
    move_a = 2'b10; move_b = 2'b11; move_a_vld = 1'b1; move_b_vld = 1'b1;
    push_round(rule_result(2'b10, 2'b11));
    tick();
    move_a_vld = 1'b0; move_b_vld = 1'b0;
    got_v = {round_result, score_a, score_b};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL b_wins_round: got %h, required %h", got_v, exp_v);
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== S_IDLE || result_vld !== 1'b0 || score_a !== '0 || score_b !== '0 || round_result !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: state=%0d vld=%b sa=%0d sb=%0d res=%b, required 0 0 0 0 00",
               state, result_vld, score_a, score_b, round_result);
    end
    exp_sa = '0;
    exp_sb = '0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (state !== S_IDLE) begin
      n_err++;
      $display("FAIL post_reset_idle: state=%0d, required 0", state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_same_cycle_win();
    test_lockout_draw();
    test_forfeit_match();
    test_invalid_freeze_void();
    test_reset_in_reveal();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
